// File: rtl/dg0045_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dg0045_fetch_pkg : shared types/constants for the DG0045 ROM fetch  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package dg0045_fetch_pkg;

    localparam int         c_half_w   = 5;
    localparam int         c_pc_w     = 10;
    localparam logic [7:0] c_nop_byte = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SET_HI = 2'd1,
        ST_SET_LO = 2'd2,
        ST_REQ    = 2'd3
    } fetch_state_t;

    // Counter must hold max(a,b)-1; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dg0045_fetch_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dg0045_fetch_timer : loadable down-counter with zero flag           |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module dg0045_fetch_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/dg0045_rom_fetch_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dg0045_rom_fetch_bridge : PC_HL capture + req/ack program fetch     |
// | Optional one-entry hit cache: DG0045_FETCH_HIT_CACHE_EN            |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module dg0045_rom_fetch_bridge
    import dg0045_fetch_pkg::*;
#(
    parameter int         SETTLE_CYCLES  = 2,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [7:0] NOP_BYTE       = c_nop_byte
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic [4:0]  pc_hl,
    output logic        pc_mux,
    output logic [9:0]  rom_addr,
    output logic        rom_req,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output logic [7:0]  instr,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_err,
    output logic        overrun
);

    localparam int               c_cnt_w     = cnt_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_settle_ld  = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_ld = c_cnt_w'(TIMEOUT_CYCLES - 1);

    fetch_state_t        r_state;
    logic                r_pc_mux;
    logic [c_half_w-1:0] r_hi;
    logic [c_pc_w-1:0]   r_rom_addr;
    logic                r_rom_req;
    logic [7:0]          r_instr;
    logic                r_instr_valid;
    logic                r_busy;
    logic                r_fetch_err;
    logic                r_overrun;

    logic                w_load;
    logic [c_cnt_w-1:0]  w_load_val;
    logic                w_dec;
    logic                w_zero;
    logic                w_hit;
    logic [c_pc_w-1:0]   w_new_addr;

    assign w_new_addr = {r_hi, pc_hl};

    dg0045_fetch_timer #(
        .CNT_W (c_cnt_w)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // Timer is reloaded on every state entry, so it only counts down within a state.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fetch_start) begin
                    w_load     = 1'b1;
                    w_load_val = c_settle_ld;
                end
            end
            ST_SET_HI: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = c_settle_ld;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_SET_LO: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = c_timeout_ld;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_REQ: begin
                w_dec = ~rom_ack;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

`ifdef DG0045_FETCH_HIT_CACHE_EN
    logic [c_pc_w-1:0] r_tag;
    logic              r_tag_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
        end else if (r_state == ST_REQ) begin
            if (rom_ack) begin
                r_tag       <= r_rom_addr;
                r_tag_valid <= 1'b1;
            end else if (w_zero) begin
                r_tag_valid <= 1'b0;
            end
        end
    end

    assign w_hit = r_tag_valid && (r_tag == w_new_addr);
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc_mux      <= 1'b1;
            r_hi          <= '0;
            r_rom_addr    <= '0;
            r_rom_req     <= 1'b0;
            r_instr       <= NOP_BYTE;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            // A strobe on the returning edge still sees REQ and is flagged.
            if (fetch_start && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_pc_mux <= 1'b1;
                    if (fetch_start) begin
                        r_busy  <= 1'b1;
                        r_state <= ST_SET_HI;
                    end
                end
                ST_SET_HI: begin
                    if (w_zero) begin
                        r_hi     <= pc_hl;
                        r_pc_mux <= 1'b0;
                        r_state  <= ST_SET_LO;
                    end
                end
                ST_SET_LO: begin
                    if (w_zero) begin
                        r_rom_addr <= w_new_addr;
                        r_pc_mux   <= 1'b1;
                        if (w_hit) begin
                            r_instr_valid <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= ST_IDLE;
                        end else begin
                            r_rom_req <= 1'b1;
                            r_state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (rom_ack) begin
                        r_instr       <= rom_data;
                        r_instr_valid <= 1'b1;
                        r_rom_req     <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (w_zero) begin
                        r_instr       <= NOP_BYTE;
                        r_fetch_err   <= 1'b1;
                        r_instr_valid <= 1'b1;
                        r_rom_req     <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc_mux      = r_pc_mux;
    assign rom_addr    = r_rom_addr;
    assign rom_req     = r_rom_req;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign busy        = r_busy;
    assign fetch_err   = r_fetch_err;
    assign overrun     = r_overrun;

    a_req_busy : assert property (@(posedge clk) disable iff (rst) r_rom_req |-> r_busy);
    a_valid_idle : assert property (@(posedge clk) disable iff (rst) r_instr_valid |-> !r_busy);

endmodule

`default_nettype wire

// File: tb/tb_dg0045_rom_fetch_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dg0045_rom_fetch_bridge : randomized bench with timing model    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_dg0045_rom_fetch_bridge;

    localparam int         c_s   = 2;
    localparam int         c_t   = 16;
    localparam logic [7:0] c_nop = 8'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_start;
    logic [4:0] pc_hl;
    logic       pc_mux;
    logic [9:0] rom_addr;
    logic       rom_req;
    logic       rom_ack;
    logic [7:0] rom_data;
    logic [7:0] instr;
    logic       instr_valid;
    logic       busy;
    logic       fetch_err;
    logic       overrun;

    logic [9:0] core_pc;
    int         n_checks = 0;
    int         n_errors = 0;

    logic [7:0] m_instr;
    logic       m_err;
    logic       m_ovr;
    logic [9:0] m_last_ok;
    logic       m_last_ok_v;

    always #5 clk = ~clk;

    // Core model: PC_HL shows the high half while pc_mux=1, else the low half.
    assign pc_hl = pc_mux ? core_pc[9:5] : core_pc[4:0];

    dg0045_rom_fetch_bridge #(
        .SETTLE_CYCLES  (c_s),
        .TIMEOUT_CYCLES (c_t),
        .NOP_BYTE       (c_nop)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .pc_hl       (pc_hl),
        .pc_mux      (pc_mux),
        .rom_addr    (rom_addr),
        .rom_req     (rom_req),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .busy        (busy),
        .fetch_err   (fetch_err),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
        end
    endtask

    // ack_lat < 0: never acknowledge. extra_k >= 0: second strobe after edge extra_k.
    task automatic run_fetch(input logic [9:0] addr, input logic [7:0] data,
                             input int ack_lat, input int extra_k);
        int e;
        e = (ack_lat < 0) ? (2 * c_s + c_t) : (2 * c_s + 1 + ack_lat);
        @(negedge clk);
        core_pc     = addr;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        for (int k = 0; k <= e + 3; k++) begin
            if (extra_k >= 0 && k == extra_k + 1) m_ovr = 1'b1;
            if (k == e) begin
                if (ack_lat >= 0) begin
                    m_instr     = data;
                    m_last_ok   = addr;
                    m_last_ok_v = 1'b1;
                end else begin
                    m_instr     = c_nop;
                    m_err       = 1'b1;
                    m_last_ok_v = 1'b0;
                end
            end
            check("busy", busy, k < e);
            check("rom_req", rom_req, (k >= 2 * c_s) && (k < e));
            check("pc_mux", pc_mux, !((k >= c_s) && (k < 2 * c_s)));
            check("instr_valid", instr_valid, k == e);
            check("instr", instr, m_instr);
            check("fetch_err", fetch_err, m_err);
            check("overrun", overrun, m_ovr);
            if (k >= 2 * c_s) check("rom_addr", rom_addr, addr);

            fetch_start = (k == extra_k);
            if (ack_lat >= 0 && k == 2 * c_s + ack_lat) begin
                rom_ack  = 1'b1;
                rom_data = data;
            end else if (k < 2 * c_s || k >= e) begin
                rom_ack  = 1'($urandom_range(0, 1));
                rom_data = 8'($urandom);
            end else begin
                rom_ack  = 1'b0;
                rom_data = 8'($urandom);
            end
            @(negedge clk);
        end
        fetch_start = 1'b0;
        rom_ack     = 1'b0;
    endtask

    task automatic reset_in_req(input logic [9:0] addr);
        @(negedge clk);
        core_pc     = addr;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        repeat (2 * c_s + 1) @(negedge clk);
        check("req_before_rst", rom_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_rom_req", rom_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pc_mux", pc_mux, 1'b1);
        check("rst_instr", instr, c_nop);
        check("rst_fetch_err", fetch_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_rom_addr", rom_addr, 10'h000);
        @(negedge clk);
        rst         = 1'b0;
        m_instr     = c_nop;
        m_err       = 1'b0;
        m_ovr       = 1'b0;
        m_last_ok_v = 1'b0;
    endtask

    initial begin
        logic [9:0] a;
        logic [7:0] d;
        int         lat;
        int         xk;
        int         e;

        rst         = 1'b1;
        fetch_start = 1'b0;
        rom_ack     = 1'b0;
        rom_data    = 8'h00;
        core_pc     = 10'h000;
        m_instr     = c_nop;
        m_err       = 1'b0;
        m_ovr       = 1'b0;
        m_last_ok   = 10'h000;
        m_last_ok_v = 1'b0;

        #3;
        check("reset_pc_mux", pc_mux, 1'b1);
        check("reset_rom_addr", rom_addr, 10'h000);
        check("reset_rom_req", rom_req, 1'b0);
        check("reset_instr", instr, c_nop);
        check("reset_instr_valid", instr_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_flags", {fetch_err, overrun}, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_fetch(10'b10110_00011, 8'hC5, 0, -1);
        run_fetch(10'h155, 8'h77, -1, -1);
        run_fetch(10'h2A5, 8'h3C, 1, c_s);
        run_fetch(10'h0F0, 8'h99, 2, 2 * c_s + 2);
        reset_in_req(10'h1E1);
        run_fetch(10'h2A5, 8'h5A, 0, -1);
        run_fetch(10'h011, 8'hE7, c_t - 1, -1);

        for (int i = 0; i < 30; i++) begin
            a = 10'($urandom);
            while (m_last_ok_v && a == m_last_ok) a = 10'($urandom);
            d   = 8'($urandom);
            lat = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, c_t - 1));
            e   = (lat < 0) ? (2 * c_s + c_t) : (2 * c_s + 1 + lat);
            xk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, e - 1)) : -1;
            run_fetch(a, d, lat, xk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
